// File: rtl/cache_ctrl_if.sv
// Signal bundle around the cache controller: processor request port, cache
// control/status pins and memory request pins.
interface cache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  logic        c_enable;
  logic        c_comp;
  logic        c_write;
  logic        c_valid_in;
  logic [4:0]  c_tag_in;
  logic [7:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data_in;
  logic        c_hit;
  logic        c_dirty;
  logic        c_valid;
  logic        c_err;
  logic [4:0]  c_tag_out;
  logic [15:0] c_data_out;

  logic [15:0] m_addr;
  logic [15:0] m_data_in;
  logic        m_wr;
  logic        m_rd;
  logic [15:0] m_data_out;
  logic        m_stall;
  logic        m_err;

  modport master (
    input  Addr, DataIn, Rd, Wr,
    output Done, Stall, CacheHit, err,
    output c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
    input  c_hit, c_dirty, c_valid, c_err, c_tag_out, c_data_out,
    output m_addr, m_data_in, m_wr, m_rd,
    input  m_data_out, m_stall, m_err
  );

  modport slave (
    output Addr, DataIn, Rd, Wr,
    input  Done, Stall, CacheHit, err,
    input  c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
    output c_hit, c_dirty, c_valid, c_err, c_tag_out, c_data_out,
    input  m_addr, m_data_in, m_wr, m_rd,
    output m_data_out, m_stall, m_err
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: compare access, dirty-victim writeback,
// pipelined line refill from a fixed-latency memory, then a retried compare.
module cache_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int WORDS   = 4
) (
  input logic         clk,
  input logic         rst,
  cache_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(WORDS + MEM_LAT);
  localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WORDS + MEM_LAT - 1);
  localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(MEM_LAT);

  typedef enum logic [2:0] {IDLE, COMP, WB, FILL, RETRY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] fill_j;
  logic [15:0]      req_addr;
  logic [15:0]      req_data;
  logic             req_wr;
  logic [4:0]       victim_tag;
  logic             sticky_err;
  logic             accept;
  logic             capture_victim;
  logic             bad_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_wr     <= 1'b0;
      victim_tag <= '0;
      sticky_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        req_addr <= bus.Addr;
        req_data <= bus.DataIn;
        req_wr   <= bus.Wr;
      end
      if (bad_req)        sticky_err <= 1'b1;
      if (capture_victim) victim_tag <= bus.c_tag_out;
    end
  end

  // Refill index j trails the issue index k by the memory latency.
  assign fill_j  = cnt - LAT_C;
  assign bus.err = sticky_err | bus.c_err | bus.m_err;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    accept         = 1'b0;
    bad_req        = 1'b0;
    capture_victim = 1'b0;
    bus.Done       = 1'b0;
    bus.CacheHit   = 1'b0;
    bus.Stall      = (state != IDLE);
    bus.c_enable   = 1'b0;
    bus.c_comp     = 1'b0;
    bus.c_write    = 1'b0;
    bus.c_valid_in = 1'b0;
    bus.c_tag_in   = req_addr[15:11];
    bus.c_index    = req_addr[10:3];
    bus.c_offset   = '0;
    bus.c_data_in  = '0;
    bus.m_addr     = '0;
    bus.m_data_in  = '0;
    bus.m_wr       = 1'b0;
    bus.m_rd       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.Rd ^ bus.Wr) begin
          accept     = 1'b1;
          state_next = COMP;
        end else if (bus.Rd && bus.Wr) begin
          bad_req = 1'b1;
        end
      end

      COMP, RETRY: begin
        bus.c_enable  = 1'b1;
        bus.c_comp    = 1'b1;
        bus.c_write   = req_wr;
        bus.c_offset  = req_addr[2:0];
        bus.c_data_in = req_data;
        if (state == RETRY) begin
          bus.Done   = 1'b1;
          state_next = IDLE;
        end else if (bus.c_hit && bus.c_valid) begin
          bus.Done     = 1'b1;
          bus.CacheHit = 1'b1;
          state_next   = IDLE;
        end else if (bus.c_valid && bus.c_dirty) begin
          capture_victim = 1'b1;
          cnt_next       = '0;
          state_next     = WB;
        end else begin
          cnt_next   = '0;
          state_next = FILL;
        end
      end

      WB: begin
        bus.c_enable  = 1'b1;
        bus.c_offset  = {cnt[1:0], 1'b0};
        bus.m_wr      = 1'b1;
        bus.m_addr    = {victim_tag, req_addr[10:3], cnt[1:0], 1'b0};
        bus.m_data_in = bus.c_data_out;
        if (!bus.m_stall) begin
          if (cnt == WB_LAST) begin
            cnt_next   = '0;
            state_next = FILL;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end

      FILL: begin
        if (cnt < WORDS_C) begin
          bus.m_rd   = 1'b1;
          bus.m_addr = {req_addr[15:3], cnt[1:0], 1'b0};
        end
        // A stalled memory freezes its pipeline, so the capture is held too.
        if (cnt >= LAT_C && !bus.m_stall) begin
          bus.c_enable   = 1'b1;
          bus.c_write    = 1'b1;
          bus.c_valid_in = 1'b1;
          bus.c_offset   = {fill_j[1:0], 1'b0};
          bus.c_data_in  = bus.m_data_out;
        end
        if (!bus.m_stall) begin
          if (cnt == FILL_LAST) begin
            cnt_next   = '0;
            state_next = RETRY;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Controller FSM between the processor-facing memory interface and the direct-mapped cache / four-bank main memory pair inside the memory system.
- Accepts single Rd or Wr requests and performs a compare access.
- On a miss: writes back a dirty victim line, refills the line from memory, then retries the compare.
- Drives the cache control pins and the memory request pins.

Parameters:
- MEM_LAT, 2, cycles from mem_rd issue to valid mem_data_out
- WORDS, 4, 16-bit words per line (offsets 0,2,4,6)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Addr  in  16  request address: tag [15:11], index [10:3], offset [2:0]
- DataIn  in  16  write data
- Rd  in  1  read request
- Wr  in  1  write request
- Done  out  1  one-cycle completion pulse
- Stall  out  1  controller busy
- CacheHit  out  1  request satisfied on first compare
- err  out  1  error
- c_enable, c_comp, c_write, c_valid_in  out  1 each  cache controls
- c_tag_in  out  5  cache tag
- c_index  out  8  cache index
- c_offset  out  3  cache offset
- c_data_in  out  16  cache data
- c_hit, c_dirty, c_valid, c_err  in  1 each  cache status
- c_tag_out  in  5  victim tag
- c_data_out  in  16  cache data
- m_addr  out  16  memory address
- m_data_in  out  16  memory write data
- m_wr, m_rd  out  1 each  memory strobes
- m_data_out  in  16  memory read data
- m_stall  in  1  memory cannot accept this cycle
- m_err  in  1  memory error

Behaviour:
- Reset: state IDLE; all outputs 0; latched request cleared. Reset mid-miss abandons the sequence; no further memory strobes are issued.
- IDLE
  - Stall=0.
  - Rd xor Wr accepts the request: latch Addr, DataIn and op; go to COMP. Nothing is accepted in any other state.
  - Rd&Wr: no access; set sticky err, cleared only by rst.
- COMP
  - Drive c_enable=1, c_comp=1, c_write=op_wr, latched tag/index/offset/data.
  - c_hit&c_valid: Done=1, CacheHit=1 this cycle; return to IDLE. Read data is on c_data_out that cycle.
  - Miss with c_valid&c_dirty: capture c_tag_out as victim tag; go to WB0.
  - Other misses: go to FILL0.
- WBi (i=0..3)
  - c_enable=1, c_comp=0, c_write=0, c_offset=2i.
  - m_wr=1, m_addr={victim_tag,index,2i}, m_data_in=c_data_out.
  - Advance only when m_stall=0; otherwise hold and re-drive the same values. WB3 goes to FILL0.
- FILLk (k=0..WORDS+MEM_LAT-1)
  - Issue side: for k<4, m_rd=1, m_addr={tag,index,2k}. Hold the whole FILL sequence while m_stall=1.
  - Capture side: for k>=MEM_LAT, j=k-MEM_LAT: c_enable=1, c_comp=0, c_write=1, c_valid_in=1, c_offset=2j, c_data_in=m_data_out.
  - Last FILL goes to RETRY.
- RETRY
  - Same drive as COMP; hit is guaranteed.
  - Done=1, CacheHit=0; go to IDLE.
  - A write marks the line dirty via the comp-write.
- Latency
  - Hit: Done in the cycle after acceptance.
  - Clean miss: 1+WORDS+MEM_LAT+1 = 8 cycles.
  - Dirty miss: 12 cycles.
  - Add any m_stall cycles to each.
- Stall=1 in every state except IDLE. Done never asserts together with Stall=0 in the same cycle as a new acceptance.
- err = sticky_err | c_err | m_err (combinational for c_err and m_err).
- c_tag_in/c_index always reflect the latched request, except during WB, where c_index is held.

Test Plan:
- Reset, then Rd to 0x0000 on a cold cache -> FILL reads at 0x0000/2/4/6; Done on cycle 8; CacheHit=0; m_wr never asserted.
- Repeat Rd 0x0004 -> Done in the cycle after acceptance, CacheHit=1, DataOut equals word 2 of memory.
- Wr 0x1234 to 0x0002 (hit), then Rd 0x0802 (same index, new tag) -> WB issues m_wr to 0x0000/2/4/6 with m_data_in at 0x0002 = 0x1234; Done on cycle 12; CacheHit=0.
- m_stall held high for 3 cycles during WB1 -> m_addr/m_data_in held stable; Done delayed exactly 3 cycles.
- Rd=Wr=1 in IDLE -> err=1 persisting, no cache/memory strobes; rst clears err.
- rst asserted in FILL2 -> next cycle state IDLE, Stall=0, m_rd=0, Done never pulses.
